// File: rtl/baopoco_fft_shift_ctrl_pkg.sv
// Shared types and register bit positions for the FFT shift controller.
package baopoco_fft_shift_ctrl_pkg;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    RUN       = 2'd1,
    PENDING   = 2'd2
  } state_t;

  localparam int CFG_CLR  = 30;
  localparam int CFG_AUTO = 31;

endpackage

// File: rtl/baopoco_fft_shift_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module baopoco_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/baopoco_fft_shift_ctrl.sv
// Applies software shift schedules on FFT frame boundaries, counts
// overflowing frames and optionally raises the schedule on overflow.
module baopoco_fft_shift_ctrl
  import baopoco_fft_shift_ctrl_pkg::*;
#(
  parameter int SHIFT_W = 12,
  parameter int CNT_W   = 32
) (
  input  logic               user_clk,
  input  logic               user_rst,
  input  logic [31:0]        cfg_in,
  input  logic               sync_in,
  input  logic               of_in,
  output logic [SHIFT_W-1:0] shift_out,
  output logic               sync_out,
  output logic               pending_out,
  output logic               of_sticky,
  output logic [CNT_W-1:0]   of_frames
);

  state_t state, state_nx;

  logic [SHIFT_W-1:0] req;
  logic [SHIFT_W-1:0] req_q;
  logic [SHIFT_W-1:0] shift_inc;
  logic               frame_of;
  logic               clr_q;
  logic               change;
  logic               apply;
  logic               auto_up;
  logic               acct;
  logic               clr;
  logic               unused_cfg;

  assign req        = cfg_in[SHIFT_W-1:0];
  assign unused_cfg = ^cfg_in[29:SHIFT_W];
  assign change     = (req != req_q);

  always_comb begin
    state_nx = state;
    apply    = 1'b0;
    unique case (state)
      WAIT_SYNC: begin
        if (sync_in) begin
          apply    = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (change) begin
          if (sync_in) apply = 1'b1;
          else state_nx = PENDING;
        end
      end
      PENDING: begin
        if (sync_in) begin
          apply    = 1'b1;
          state_nx = RUN;
        end
      end
      default: state_nx = WAIT_SYNC;
    endcase
  end

  // Sets the lowest clear bit; all-ones maps to itself.
  assign shift_inc = shift_out | (shift_out + SHIFT_W'(1));

  assign acct    = sync_in & frame_of & (state != WAIT_SYNC);
  assign auto_up = sync_in & frame_of & cfg_in[CFG_AUTO] & ~apply;
  assign clr     = cfg_in[CFG_CLR] & ~clr_q;

  assign pending_out = (state == PENDING);

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state     <= WAIT_SYNC;
      req_q     <= '0;
      shift_out <= '1;
      sync_out  <= 1'b0;
      frame_of  <= 1'b0;
      clr_q     <= 1'b0;
      of_sticky <= 1'b0;
    end else begin
      state    <= state_nx;
      req_q    <= req;
      sync_out <= sync_in;
      clr_q    <= cfg_in[CFG_CLR];
      if (apply) begin
        shift_out <= req;
      end else if (auto_up) begin
        shift_out <= shift_inc;
      end
      // The sync cycle's flag belongs to the frame it starts.
      if (sync_in) frame_of <= of_in;
      else frame_of <= frame_of | of_in;
      if (clr) of_sticky <= 1'b0;
      else if (acct) of_sticky <= 1'b1;
    end
  end

  baopoco_sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk (user_clk),
    .rst (user_rst),
    .clr (clr),
    .inc (acct),
    .cnt (of_frames)
  );

endmodule

// File: doc/baopoco_fft_shift_ctrl.md
# baopoco_fft_shift_ctrl

Frame-synchronous controller for the FFT shift schedule. Sits in the `user_clk` domain between the software-written shift register output (32-bit `user_data_out`) and the FFT datapath's shift input. Software changes take effect only on FFT frame boundaries, never mid-frame. The block counts overflowing frames and can optionally raise the shift schedule automatically.

## Interface
Parameters:
- `SHIFT_W`, 12: FFT stages; width of the shift schedule.
- `CNT_W`, 32: width of the overflow-frame counter.

Ports:
- `user_clk`  in  1  single clock. The FFT datapath and the register's `user_clk` side run on it.
- `user_rst`  in  1  reset, asynchronous, active-high.
- `cfg_in`  in  32  software register value:
  - `[SHIFT_W-1:0]` requested schedule.
  - `[30]` counter clear, acts on its rising edge.
  - `[31]` auto-shift enable.
- `sync_in`  in  1  one-cycle pulse marking the first sample of an FFT frame.
- `of_in`  in  1  per-cycle FFT overflow flag.
- `shift_out`  out  SHIFT_W  active schedule to the FFT.
- `sync_out`  out  1  `sync_in` delayed one cycle.
- `pending_out`  out  1  high while a software change is waiting for a sync.
- `of_sticky`  out  1  high if any overflow frame occurred since the last clear.
- `of_frames`  out  CNT_W  saturating count of frames with overflow.

## Operation
- States:
  - WAIT_SYNC is the reset state. No frame boundary has been seen yet.
  - RUN.
  - PENDING means a request change has been detected.
- Change detection:
  - `req_q` registers `cfg_in[SHIFT_W-1:0]` every cycle.
  - A change is detected when `cfg_in[SHIFT_W-1:0] != req_q`. It is compared against the last request, not against `shift_out`, so auto-raised values are not reverted.
- WAIT_SYNC:
  - On `sync_in`, `shift_out` takes `cfg_in[SHIFT_W-1:0]` unconditionally and the state goes to RUN.
  - No overflow accounting happens in this state.
  - A change while in WAIT_SYNC stays in WAIT_SYNC.
- RUN:
  - A change without `sync_in` goes to PENDING.
  - A change coinciding with `sync_in` applies immediately and stays in RUN.
- PENDING:
  - On `sync_in`, `shift_out` takes the current `cfg_in[SHIFT_W-1:0]` and the state goes to RUN.
  - Further changes while PENDING remain PENDING. The value applied is the latest one.
- Frame overflow:
  - `frame_of` is the OR of `of_in` over the cycles strictly before each `sync_in`.
  - The `sync_in` cycle's `of_in` belongs to the new frame. `frame_of` is reloaded with that cycle's `of_in` at the sync.
- At `sync_in` in RUN or PENDING with `frame_of=1`:
  - `of_frames` increments, saturating at all-ones.
  - `of_sticky` is set to 1.
- Auto-shift: at `sync_in` with `cfg_in[31]=1`, `frame_of=1` and no manual apply in that cycle, `shift_out <= shift_out | (shift_out + 1)`.
  - This sets the lowest zero bit.
  - If `shift_out` is all ones it is unchanged.
  - A manual apply always beats auto.
- Clear: a rising edge of `cfg_in[30]` zeroes `of_frames` and `of_sticky`. Clear beats a coincident increment.

## Timing
- Reset values:
  - `shift_out` = all ones (maximum shift, safe).
  - `sync_out`, `pending_out`, `of_sticky` = 0.
  - `of_frames` = 0.
  - State = WAIT_SYNC.
  - `req_q` = 0, `frame_of` = 0.
  - The edge detector on `cfg_in[30]` = 0.
- Latency and alignment:
  - `sync_out` follows `sync_in` by exactly 1 cycle.
  - A new `shift_out` is visible in the same cycle `sync_out` is high, so the FFT samples it with its frame.
- `pending_out` equals (state == PENDING). It rises 1 cycle after the change and falls in the `sync_out` cycle.
- `of_frames` and `of_sticky` update 1 cycle after `sync_in`, i.e. aligned with `sync_out`.
- Back-to-back `sync_in` (period 1): each pulse is a frame boundary and is accounted independently.
- Reset asserted mid-frame: all outputs return to reset values asynchronously, and the block waits for a fresh `sync_in`.

## Structure
- Shared package `baopoco_fft_shift_ctrl_pkg`:
  - state enum (WAIT_SYNC, RUN, PENDING);
  - `cfg_in` bit indices `CFG_CLR=30`, `CFG_AUTO=31`.
- Sub-module `baopoco_sat_counter`: width-parameterised saturating counter with sync clear and increment. Clear has priority.
- Everything else lives in the top: FSM, change detector, clear edge detector, overflow accumulator, and the auto-shift adder.

## Test plan
- Reset, then first `sync_in` with `cfg_in[11:0]=0x555`:
  - `shift_out=0xFFF` until `sync_out`;
  - `shift_out=0x555` in the `sync_out` cycle;
  - `of_frames=0` even though `of_in` pulsed before the first sync.
- In RUN, change the request to 0x0F0 mid-frame: `pending_out=1` next cycle; `shift_out` switches to 0x0F0 with the next `sync_out`; `pending_out=0` in that cycle.
- Auto enabled, `shift_out=0x00F`, one `of_in` pulse per frame over 3 frames:
  - `shift_out` goes 0x01F, 0x03F, 0x07F;
  - `of_frames=3`; `of_sticky=1`; the request is not re-applied.
- `of_in` high only in the `sync_in` cycle: no count at that sync; count 1 at the following sync.
- Preload `of_frames` near saturation with `CNT_W=4`, then run 20 overflow frames: `of_frames` holds at 0xF.
- Clear edge coinciding with an overflowing `sync_in`: `of_frames=0` and `of_sticky=0` afterwards. Assert `user_rst` mid-frame: all outputs return to reset values immediately.
